// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one bitwise logic unit (AND/OR/XOR/XNOR) among
// NREQ requesters. A round-robin arbiter picks one request per cycle, and the
// result is held in a single-entry response slot tagged with the requester ID.
module logic_unit_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*2-1:0]     req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [CNTW-1:0]       done_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   slot_state_t      state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant_idx;
   logic [IDW-1:0]   cand_idx;
   logic [IDW-1:0]   ptr_next;
   logic             grant_valid;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] op_result;

   // The slot can take a new result when empty, or when full and draining this cycle.
   assign can_accept = (state == EMPTY) || rsp_ready;
   assign accept     = can_accept && grant_valid && !rst;
   assign rsp_valid  = (state == FULL);

   // Round-robin search: walk from ptr upward, wrapping, and take the first valid requester.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_idx = IDW'((int'(ptr) + k) % NREQ);
         for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && (cand_idx == IDW'(i)) && req_valid[i]) begin
               grant_valid = 1'b1;
               grant_idx   = IDW'(i);
            end
         end
      end
   end

   // Accept strobe is one-hot on the granted requester, and only when the slot can take it.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (grant_idx == IDW'(i));
      end
   end

   // Route the granted requester's operands and op code to the shared logic unit.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = 2'b00;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            sel_a  = req_a[i*WIDTH +: WIDTH];
            sel_b  = req_b[i*WIDTH +: WIDTH];
            sel_op = req_op[i*2 +: 2];
         end
      end
   end

   // The shared bitwise logic unit itself.
   always_comb begin
      op_result = '0;
      case (sel_op)
         2'b00:   op_result = sel_a & sel_b;
         2'b01:   op_result = sel_a | sel_b;
         2'b10:   op_result = sel_a ^ sel_b;
         default: op_result = ~(sel_a ^ sel_b);
      endcase
   end

   // Next pointer sits just past the granted requester, wrapping the last one to 0.
   always_comb begin
      ptr_next = '0;
      if (grant_idx != IDW'(NREQ - 1)) begin
         ptr_next = grant_idx + IDW'(1);
      end
   end

   // Response slot FSM, round-robin pointer and completed-transaction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         ptr      <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         done_cnt <= '0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            done_cnt <= done_cnt + CNTW'(1);
         end
         case (state)
            EMPTY: begin
               if (accept) begin
                  state <= FULL;
               end
            end
            FULL: begin
               if (rsp_ready && !accept) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
         if (accept) begin
            rsp_data <= op_result;
            rsp_id   <= grant_idx;
            ptr      <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed test of the shared logic unit arbiter.
// A queue-based reference model tracks the response slot, the round-robin
// pointer and the consumed count; directed literal checks pin the model.
module tb_logic_unit_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int CNTW  = 4;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*2-1:0]     req_op;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic [CNTW-1:0]       done_cnt;

   int checks = 0;
   int errors = 0;

   logic_unit_arbiter #(
      .WIDTH(WIDTH),
      .NREQ (NREQ),
      .IDW  (IDW),
      .CNTW (CNTW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_op   (req_op),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .done_cnt (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: pending responses, pointer, and consumed count.
   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
   } rsp_t;

   rsp_t m_q[$];
   int   m_ptr   = 0;
   int   m_count = 0;
   int   m_grant;
   rsp_t m_item;

   function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0] op);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // Which requester the rules say should win right now, or -1 for none.
   function automatic int model_grant();
      if (rst) return -1;
      if (!(m_q.size() == 0 || rsp_ready)) return -1;
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [1:0] op);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_op[i*2 +: 2]        = op;
   endtask

   // Advance the model at each clock edge from the inputs the DUT also sees.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_ptr   = 0;
         m_count = 0;
      end else begin
         m_grant = model_grant();
         if (m_q.size() > 0 && rsp_ready) begin
            void'(m_q.pop_front());
            m_count = m_count + 1;
         end
         if (m_grant >= 0) begin
            m_item.id   = m_grant;
            m_item.data = logic_op(req_a[m_grant*WIDTH +: WIDTH],
                                   req_b[m_grant*WIDTH +: WIDTH],
                                   req_op[m_grant*2 +: 2]);
            m_q.push_back(m_item);
            m_ptr = (m_grant + 1) % NREQ;
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] exp_ready;
      g = model_grant();
      exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      check_output("cmp_req_ready", 32'(req_ready), 32'(exp_ready));
      check_output("cmp_rsp_valid", 32'(rsp_valid), 32'(m_q.size() > 0));
      check_output("cmp_done_cnt", 32'(done_cnt), 32'(m_count % (1 << CNTW)));
      if (m_q.size() > 0) begin
         check_output("cmp_rsp_id", 32'(rsp_id), 32'(m_q[0].id));
         check_output("cmp_rsp_data", 32'(rsp_data), 32'(m_q[0].data));
      end
   end

   task automatic apply_stimulus();
      logic [1:0]       ops [4];
      logic [WIDTH-1:0] exps[4];
      ops  = '{2'b11, 2'b00, 2'b01, 2'b10};
      exps = '{8'h33, 8'h30, 8'hFC, 8'hCC};

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("reset_rsp_id", 32'(rsp_id), 32'd0);
      check_output("reset_rsp_data", 32'(rsp_data), 32'd0);
      check_output("reset_done_cnt", 32'(done_cnt), 32'd0);
      check_output("reset_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;

      // Single requests through each op code.
      for (int i = 0; i < 4; i++) begin
         set_req(0, 8'hF0, 8'h3C, ops[i]);
         req_valid = 4'b0001;
         @(negedge clk); #1;
         check_output("single_ready", 32'(req_ready), 32'h1);
         @(posedge clk); #1;
         req_valid = '0;
         @(negedge clk); #1;
         check_output("single_rsp_valid", 32'(rsp_valid), 32'd1);
         check_output("single_rsp_id", 32'(rsp_id), 32'd0);
         check_output("single_rsp_data", 32'(rsp_data), 32'(exps[i]));
         @(posedge clk); #1;
      end

      // Reset mid-transaction while a response is held.
      rsp_ready = 1'b0;
      set_req(2, 8'hAA, 8'h0F, 2'b10);
      req_valid = 4'b0100;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      check_output("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("pre_reset_rsp_data", 32'(rsp_data), 32'hA5);
      rst = 1'b1;
      #1;
      check_output("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("midreset_done_cnt", 32'(done_cnt), 32'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;

      // Round-robin with all requesters valid.
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(8'h11 * (i + 1)), 8'hFF, 2'b10);
      req_valid = 4'b1111;
      @(negedge clk); #1;
      check_output("rr_first_grant", 32'(req_ready), 32'h1);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k == 7) req_valid = '0;
         @(negedge clk); #1;
         check_output("rr_rsp_id", 32'(rsp_id), 32'(k % NREQ));
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      check_output("rr_done_cnt", 32'(done_cnt), 32'd8);

      // Backpressure: req1 accepted once, req2 waits for the drain.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_req(1, 8'h5A, 8'hC3, 2'b00);
      set_req(2, 8'h5A, 8'hC3, 2'b01);
      req_valid = 4'b0110;
      @(negedge clk); #1;
      check_output("bp_grant1", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = 4'b0100;
      @(negedge clk); #1;
      check_output("bp_blocked", 32'(req_ready), 32'h0);
      check_output("bp_rsp_data", 32'(rsp_data), 32'h42);
      @(posedge clk); #1;
      @(negedge clk); #1;
      check_output("bp_held_data", 32'(rsp_data), 32'h42);
      check_output("bp_held_id", 32'(rsp_id), 32'd1);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      check_output("bp_grant2", 32'(req_ready), 32'h4);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      check_output("bp_rsp2_id", 32'(rsp_id), 32'd2);
      check_output("bp_rsp2_data", 32'(rsp_data), 32'hDB);

      // Wrap/skip from pointer 3.
      @(posedge clk); #1;
      req_valid = 4'b0010;
      @(negedge clk); #1;
      check_output("skip_grant1", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = 4'b1001;
      @(negedge clk); #1;
      check_output("skip_grant3", 32'(req_ready), 32'h8);
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(negedge clk); #1;
      check_output("wrap_rsp_id", 32'(rsp_id), 32'd3);
      check_output("wrap_grant0", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;

      // Counter wrap: 17 responses into a 4-bit counter.
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 17; k++) begin
         @(posedge clk); #1;
         if (k == 16) req_valid = '0;
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      check_output("cnt_wrap", 32'(done_cnt), 32'd1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      apply_stimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
